// File: rtl/rr_grant_sequencer_8.sv
// rtl/rr_grant_sequencer_8.sv - 8-requester round-robin grant sequencer driving a 3-to-8 decoder select
// Optional build macro: ARB_TIMEOUT_EN (forced release after TIMEOUT grant cycles)
module rr_grant_sequencer_8 #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] winner;
  logic       any_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;
`else
  // Without the timeout feature a grant is held until done, so no error can occur.
  assign timeout_err = 1'b0;
`endif

  // Rotating priority search: first set request starting at ptr, wrapping 7 -> 0.
  always_comb begin
    logic [2:0] cand;
    winner  = 3'd0;
    any_req = 1'b0;
    cand    = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!any_req && req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  // Grant FSM: all outputs are registered so nothing combinational reaches the decoder select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      busy        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // grant_idx keeps its last value while nobody is asking.
          if (any_req) begin
            grant_idx   <= winner;
            grant_valid <= 1'b1;
            busy        <= 1'b1;
            state       <= GRANT;
`ifdef ARB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
          end
        end
        GRANT: begin
          // req is ignored here; done takes precedence over a coincident timeout.
          if (done) begin
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 3'd1;
            state       <= RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 3'd1;
            state       <= RELEASE;
            timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        RELEASE: begin
          // Dead cycle between decoder selections, then back to arbitration.
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_grant_sequencer_8.sv
// tb/tb_rr_grant_sequencer_8.sv - self-checking bench for rr_grant_sequencer_8
module tb_rr_grant_sequencer_8;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       busy;
  logic       timeout_err;

  int n_vec = 0;
  int n_bad = 0;

  rr_grant_sequencer_8 #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .done(done),
    .grant_idx(grant_idx),
    .grant_valid(grant_valid),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting, 1 = owned, 2 = dead cycle
  int         m_phase;
  int         m_owned_cycles;
  int         m_ptr;
  int         m_idx;
  bit         m_valid;
  bit         m_busy;
  bit         m_to;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  function automatic int rr_pick(input logic [7:0] r, input int from);
    for (int k = 0; k < 8; k++) begin
      if (r[(from + k) % 8]) return (from + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_owned_cycles = 0; m_ptr = 0; m_idx = 0;
    m_valid = 0; m_busy = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    int w;
    m_to = 0;
    if (m_phase == 0) begin
      w = rr_pick(r, m_ptr);
      if (w >= 0) begin
        m_idx = w; m_valid = 1; m_busy = 1; m_phase = 1; m_owned_cycles = 1;
      end
    end else if (m_phase == 1) begin
      if (d || (TO_EN && m_owned_cycles == TIMEOUT)) begin
        m_to = !d;
        m_valid = 0; m_ptr = (m_idx + 1) % 8; m_phase = 2;
      end else begin
        m_owned_cycles++;
      end
    end else begin
      m_busy = 0; m_phase = 0;
    end
  endtask

  task automatic cmp(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got idx/valid/busy/to=%0d/%b/%b/%b want %0d/%b/%b/%b", name,
               act[5:3], act[2], act[1], act[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [5:0] dut_out();
    return {grant_idx, grant_valid, busy, timeout_err};
  endfunction

  function automatic logic [5:0] model_out();
    return {3'(m_idx), m_valid, m_busy, m_to};
  endfunction

  // One clock: drive, clock, sample 1 ns after the edge, compare with the model.
  task automatic step(input string name, input logic [7:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    model_edge(r, d);
    #1;
    cmp(name, dut_out(), model_out());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    model_reset();
    req = 8'h00; done = 1'b0;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [2:0] idx;
    logic       valid;
    logic       busy;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int n;
    int hi;

    // Table: single request, hold, release, wrap/fairness, stray done
    tbl[0]  = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{8'h20, 1'b0, 3'd5, 1'b1, 1'b1};
    tbl[2]  = '{8'h00, 1'b0, 3'd5, 1'b1, 1'b1};
    tbl[3]  = '{8'h00, 1'b0, 3'd5, 1'b1, 1'b1};
    tbl[4]  = '{8'h00, 1'b1, 3'd5, 1'b0, 1'b1};
    tbl[5]  = '{8'h00, 1'b0, 3'd5, 1'b0, 1'b0};
    tbl[6]  = '{8'h81, 1'b0, 3'd7, 1'b1, 1'b1};
    tbl[7]  = '{8'h81, 1'b1, 3'd7, 1'b0, 1'b1};
    tbl[8]  = '{8'h81, 1'b0, 3'd7, 1'b0, 1'b0};
    tbl[9]  = '{8'h81, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[10] = '{8'h81, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[11] = '{8'h81, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[12] = '{8'h81, 1'b1, 3'd7, 1'b1, 1'b1};
    tbl[13] = '{8'h00, 1'b1, 3'd7, 1'b0, 1'b1};
    tbl[14] = '{8'h00, 1'b1, 3'd7, 1'b0, 1'b0};
    tbl[15] = '{8'h00, 1'b1, 3'd7, 1'b0, 1'b0};
    tbl[16] = '{8'h00, 1'b1, 3'd7, 1'b0, 1'b0};
    tbl[17] = '{8'hFF, 1'b0, 3'd0, 1'b1, 1'b1};
    tbl[18] = '{8'hFF, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[19] = '{8'h00, 1'b0, 3'd0, 1'b0, 1'b0};

    #2;
    cmp("reset_state", dut_out(), 6'b000_0_0_0);
    do_reset();
    #1;
    cmp("after_reset", dut_out(), 6'b000_0_0_0);

    for (int i = 0; i < 20; i++) begin
      req = tbl[i].req; done = tbl[i].done;
      @(posedge clk);
      model_edge(tbl[i].req, tbl[i].done);
      #1;
      cmp($sformatf("table[%0d]", i), dut_out(), {tbl[i].idx, tbl[i].valid, tbl[i].busy, 1'b0});
    end

    // Single request held 10 cycles with req withdrawn
    do_reset();
    step("single_grant", 8'h20, 1'b0);
    for (int i = 0; i < 10; i++) step("single_hold", 8'h00, 1'b0);
    cmp("single_hold_idx", dut_out(), 6'b101_1_1_0);
    step("single_release", 8'h00, 1'b1);
    step("single_idle", 8'h00, 1'b0);
    cmp("single_busy_low", {5'd0, busy}, 6'd0);

    // Asynchronous reset in the middle of a grant to index 3
    do_reset();
    step("pre_rst_grant", 8'h08, 1'b0);
    step("pre_rst_hold", 8'h08, 1'b0);
    rst_n = 1'b0;
    #1;
    cmp("async_reset", dut_out(), 6'b000_0_0_0);
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    step("post_rst_grant", 8'h08, 1'b0);
    cmp("post_rst_idx3", dut_out(), 6'b011_1_1_0);

    // Rotation with all requesters active
    do_reset();
    for (int g = 0; g < 9; g++) begin
      n = 0;
      do begin
        step("rot_wait", 8'hFF, 1'b0);
        n++;
      end while (!grant_valid && n < 6);
      cmp($sformatf("rot_idx[%0d]", g), {grant_idx, grant_valid, 2'b00}, {3'(g % 8), 1'b1, 2'b00});
      cmp($sformatf("rot_gap[%0d]", g), 6'(n), 6'((g == 0) ? 1 : 2));
      step("rot_done", 8'hFF, 1'b1);
    end

    // Timeout behaviour (or indefinite hold without the feature)
    do_reset();
    step("to_grant", 8'h04, 1'b0);
    hi = 1;
    for (int i = 0; i < 110; i++) begin
      step("to_hold", 8'h44, 1'b0);
      if (grant_valid) hi++;
      else break;
    end
`ifdef ARB_TIMEOUT_EN
    cmp("to_valid_cycles", 6'(hi), 6'(TIMEOUT));
    cmp("to_err_pulse", {5'd0, timeout_err}, 6'd1);
    step("to_idle", 8'h44, 1'b0);
    cmp("to_err_cleared", {5'd0, timeout_err}, 6'd0);
    step("to_next_grant", 8'h44, 1'b0);
    cmp("to_next_idx6", dut_out(), 6'b110_1_1_0);
`else
    cmp("hold_100_cycles", {5'd0, (hi >= 100)}, 6'd1);
    cmp("hold_no_err", dut_out(), 6'b010_1_1_0);
    step("hold_release", 8'h44, 1'b1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r;
      logic       d;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d = ($urandom_range(0, 2) == 0);
      step("random", r, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
